// File: rtl/iob_rr_arbiter_pkg.sv
// Shared definitions for the IOb round-robin arbiter: FSM encoding, bus-width
// derivations and field offsets of the packed IOb request/response words.
package iob_rr_arbiter_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Request word is {valid, address, wdata, wstrb}, response word is {rdata, ready}.
  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int valid_bit(input int addr_w, input int data_w);
    return req_w(addr_w, data_w) - 1;
  endfunction

  function automatic int ready_bit();
    return 0;
  endfunction

  // Width of an index into n masters; never zero so that n=1 builds still elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_arbiter_pick.sv
// Rotating-priority encoder: first set request scanning from ptr upward with
// wrap-around modulo N (N need not be a power of two).
module iob_rr_pick
  import iob_rr_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter sharing one native IOb slave port between N_MASTERS
// masters, one transaction in flight, with an optional no-response watchdog.
module iob_rr_arbiter
  import iob_rr_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 0,
  parameter int REQ_W     = req_w(ADDR_W, DATA_W),
  parameter int RESP_W    = resp_w(DATA_W)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp,
  output logic [N_MASTERS-1:0]          grant,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int IDX_W = idx_w(N_MASTERS);
  localparam int CNT_W = cnt_w(TIMEOUT);
  localparam int VB    = valid_bit(ADDR_W, DATA_W);

  logic [0:0]           state;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     ptr;
  logic [CNT_W-1:0]     wd_cnt;

  logic [REQ_W-1:0]     req_arr [N_MASTERS];
  logic [N_MASTERS-1:0] req_valid;
  logic [N_MASTERS-1:0] pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic                 in_busy;
  logic                 s_ready;
  logic                 wd_hit;
  logic                 done;
  logic [IDX_W-1:0]     ptr_next;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_split
    assign req_arr[i]   = m_req[i*REQ_W +: REQ_W];
    assign req_valid[i] = req_arr[i][VB];
  end

  iob_rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (req_valid),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  assign in_busy  = (state == ST_BUSY);
  assign s_ready  = s_resp[ready_bit()];
  // A genuine slave ready in the limit cycle wins over the watchdog.
  assign wd_hit   = (TIMEOUT > 0) && in_busy && !s_ready && (wd_cnt == CNT_W'(TIMEOUT));
  assign done     = in_busy && (s_ready || wd_hit);
  assign ptr_next = (owner == IDX_W'(N_MASTERS - 1)) ? '0 : owner + IDX_W'(1);

  // Request valid is gated by state, so it drops the moment the FSM leaves BUSY.
  assign s_req       = in_busy ? req_arr[owner] : '0;
  assign busy        = in_busy;
  assign timeout_err = wd_hit;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_resp
    assign m_resp[i*RESP_W +: RESP_W] = !grant[i] ? '0
                                      : wd_hit   ? RESP_W'(1)
                                      :            s_resp;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state  <= ST_IDLE;
      grant  <= '0;
      owner  <= '0;
      ptr    <= '0;
      wd_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state  <= ST_BUSY;
            grant  <= pick;
            owner  <= pick_idx;
            wd_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (done) begin
            state  <= ST_IDLE;
            grant  <= '0;
            ptr    <= ptr_next;
            wd_cnt <= '0;
          end else if (TIMEOUT > 0) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Self-checking bench for iob_rr_arbiter: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a behavioural model.
module tb_iob_rr_arbiter;

  localparam int N      = 3;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SW     = DW / 8;
  localparam int TO     = 8;
  localparam int REQ_W  = 1 + AW + DW + SW;
  localparam int RESP_W = DW + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N*REQ_W-1:0]    m_req;
  wire  [N*RESP_W-1:0]   m_resp;
  wire  [REQ_W-1:0]      s_req;
  logic [RESP_W-1:0]     s_resp;
  wire  [N-1:0]          grant;
  wire                   busy;
  wire                   timeout_err;

  always #5 clk = ~clk;

  iob_rr_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req       (m_req),
    .m_resp      (m_resp),
    .s_req       (s_req),
    .s_resp      (s_resp),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Master-side stimulus
  logic          mv [N];
  logic [AW-1:0] ma [N];
  logic [DW-1:0] md [N];
  logic [SW-1:0] ms [N];
  logic          s_ready;
  logic [DW-1:0] s_rdata;

  always_comb begin
    m_req = '0;
    for (int i = 0; i < N; i++) m_req[i*REQ_W +: REQ_W] = {mv[i], ma[i], md[i], ms[i]};
  end
  assign s_resp = {s_rdata, s_ready};

  // Bench control
  int      n_vec = 0;
  int      n_err = 0;
  bit      cont [N];
  bit      last_rdy [N];
  bit      rnd_mode, inject, rd_fixed_en;
  logic [DW-1:0] rd_fixed;
  int      slave_lat, s_wait;

  // Reference model: owner (-1 = idle), rotating pointer, watchdog age
  int      mo_owner, mo_ptr, mo_cnt;
  bit      exp_to;

  // Observed outputs of the current cycle
  logic [N-1:0]        obs_grant;
  logic                obs_busy, obs_to;
  logic [REQ_W-1:0]    obs_sreq;
  logic [N*RESP_W-1:0] obs_mresp;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic new_req(input int i);
    mv[i] = 1'b1;
    ma[i] = $urandom;
    md[i] = $urandom;
    ms[i] = SW'($urandom);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++)
      if (last_rdy[i]) begin
        if (cont[i]) new_req(i);
        else mv[i] = 1'b0;
      end
    if (rnd_mode)
      for (int i = 0; i < N; i++)
        if (!mv[i] && $urandom_range(0, 2) == 0) new_req(i);
    if (mo_owner >= 0) begin
      s_wait++;
      if (rnd_mode && s_wait == 1) slave_lat = $urandom_range(0, 10);
      s_ready = (slave_lat != 0) && (s_wait == slave_lat);
    end else begin
      s_wait  = 0;
      s_ready = 1'b0;
    end
    s_rdata = rd_fixed_en ? rd_fixed : $urandom;
    if (inject && s_ready) begin
      new_req(1);
      inject = 1'b0;
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0]        eg;
    logic                eb;
    logic [REQ_W-1:0]    esr;
    logic [N*RESP_W-1:0] emr;
    #1;
    eb     = (mo_owner >= 0);
    eg     = eb ? N'(1 << mo_owner) : '0;
    exp_to = (TO > 0) && eb && !s_ready && (mo_cnt == TO);
    esr    = eb ? {mv[mo_owner], ma[mo_owner], md[mo_owner], ms[mo_owner]} : '0;
    emr    = '0;
    if (eb) emr[mo_owner*RESP_W +: RESP_W] = exp_to ? RESP_W'(1) : {s_rdata, s_ready};
    obs_grant = grant;
    obs_busy  = busy;
    obs_to    = timeout_err;
    obs_sreq  = s_req;
    obs_mresp = m_resp;
    check("grant", obs_grant, eg);
    check("busy", obs_busy, eb);
    check("timeout_err", obs_to, exp_to);
    check("s_req", obs_sreq, esr);
    check("m_resp", obs_mresp, emr);
    for (int i = 0; i < N; i++) last_rdy[i] = emr[i*RESP_W];
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) begin
      mo_owner = -1;
      mo_ptr   = 0;
      mo_cnt   = 0;
    end else if (mo_owner >= 0) begin
      if (s_ready || exp_to) begin
        mo_ptr   = (mo_owner + 1) % N;
        mo_owner = -1;
      end else begin
        mo_cnt++;
      end
    end else begin
      for (int k = 0; k < N; k++)
        if (mo_owner < 0 && mv[(mo_ptr + k) % N]) begin
          mo_owner = (mo_ptr + k) % N;
          mo_cnt   = 0;
        end
    end
    @(negedge clk);
  endtask

  task automatic tick();
    drive();
    check_cycle();
    adv();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0;
      cont[i] = 1'b0;
    end
    rnd_mode    = 1'b0;
    inject      = 1'b0;
    rd_fixed_en = 1'b0;
    slave_lat   = 1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int            rcnt, tocnt, ent, toi, nseq;
    logic [N-1:0]  first_g, prev, seq [4];
    logic [REQ_W-1:0] sreq1;
    logic [RESP_W-1:0] m0_or;
    logic [DW-1:0] got;

    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0; ma[i] = '0; md[i] = '0; ms[i] = '0;
      cont[i] = 1'b0; last_rdy[i] = 1'b0;
    end
    s_ready = 1'b0; s_rdata = '0; rd_fixed = '0;
    rnd_mode = 1'b0; inject = 1'b0; rd_fixed_en = 1'b0;
    slave_lat = 1; s_wait = 0;
    mo_owner = -1; mo_ptr = 0; mo_cnt = 0; exp_to = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // Single master write, slave latency 3
    mv[0] = 1'b1; ma[0] = 32'h8000_0010; md[0] = 32'hDEAD_BEEF; ms[0] = 4'hF;
    slave_lat = 3; rcnt = 0; first_g = '0; sreq1 = '0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (t == 1) sreq1 = obs_sreq;
      if (obs_mresp[0]) rcnt++;
      if (first_g == '0) first_g = obs_grant;
    end
    check("single_sreq", sreq1, {1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF});
    check("single_ready_once", rcnt, 1);
    check("single_grant", first_g, 3'b001);
    check("single_grant_idle", obs_grant, 3'b000);
    // ptr is now 1: m0 and m2 together must go to m2
    new_req(0); new_req(2); slave_lat = 1;
    tick(); tick();
    check("ptr_after_single", obs_grant, 3'b100);
    for (int t = 0; t < 6; t++) tick();

    // Full contention, latency 1
    do_reset();
    for (int i = 0; i < N; i++) begin cont[i] = 1'b1; new_req(i); end
    slave_lat = 1; nseq = 0; prev = '0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (obs_grant != '0 && prev == '0 && nseq < 4) begin seq[nseq] = obs_grant; nseq++; end
      prev = obs_grant;
    end
    check("rr_seq0", seq[0], 3'b001);
    check("rr_seq1", seq[1], 3'b010);
    check("rr_seq2", seq[2], 3'b100);
    check("rr_seq3", seq[3], 3'b001);
    for (int i = 0; i < N; i++) cont[i] = 1'b0;
    for (int t = 0; t < 10; t++) tick();

    // Read by m1 with fixed slave data
    do_reset();
    new_req(1); ma[1] = 32'h0000_0100; md[1] = '0; ms[1] = '0;
    rd_fixed_en = 1'b1; rd_fixed = 32'h1234_5678; slave_lat = 2;
    m0_or = '0; got = '0;
    for (int t = 0; t < 6; t++) begin
      tick();
      m0_or = m0_or | obs_mresp[0 +: RESP_W];
      if (obs_mresp[RESP_W]) got = obs_mresp[RESP_W+1 +: DW];
    end
    check("read_rdata_m1", got, 32'h1234_5678);
    check("read_m0_quiet", m0_or, '0);
    rd_fixed_en = 1'b0;

    // Watchdog: no slave answer, then answer exactly in the limit cycle
    do_reset();
    new_req(0); slave_lat = 0; ent = -1; toi = -1; tocnt = 0;
    for (int t = 0; t < 14; t++) begin
      tick();
      if (ent < 0 && obs_busy) ent = t;
      if (obs_to) begin tocnt++; toi = t; end
    end
    check("wd_pulse_once", tocnt, 1);
    check("wd_delay", toi, ent + TO);
    new_req(0); slave_lat = TO + 1; tocnt = 0; rcnt = 0;
    for (int t = 0; t < 14; t++) begin
      tick();
      if (obs_to) tocnt++;
      if (obs_mresp[0]) rcnt++;
    end
    check("wd_race_no_pulse", tocnt, 0);
    check("wd_race_ready", rcnt, 1);

    // Reset in the middle of a transaction
    do_reset();
    new_req(0); slave_lat = 0;
    for (int t = 0; t < 3; t++) tick();
    rst = 1'b1; mv[0] = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("rstmid_busy", obs_busy, 1'b0);
    check("rstmid_grant", obs_grant, 3'b000);
    check("rstmid_svalid", obs_sreq[REQ_W-1], 1'b0);
    new_req(1); slave_lat = 2; rcnt = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (obs_mresp[RESP_W]) rcnt++;
    end
    check("rstmid_m1_served", rcnt, 1);

    // New request in the completion cycle
    do_reset();
    new_req(0); cont[0] = 1'b1; slave_lat = 2; inject = 1'b1;
    nseq = 0; prev = '0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (obs_grant != '0 && prev == '0 && nseq < 4) begin seq[nseq] = obs_grant; nseq++; end
      prev = obs_grant;
    end
    check("samecyc_first", seq[0], 3'b001);
    check("samecyc_m1_wins", seq[1], 3'b010);
    cont[0] = 1'b0;
    for (int t = 0; t < 10; t++) tick();

    // Randomized traffic against the model
    do_reset();
    rnd_mode = 1'b1;
    for (int t = 0; t < 400; t++) tick();
    rnd_mode = 1'b0;
    for (int t = 0; t < 40; t++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
